pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline; sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their write-enable, bubble and flush controls.
- Detects load-use hazards and redirects on taken branches and jumps.
- Runs a multi-cycle multiply FSM that freezes the front end while EX is occupied.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stall, branch/jump redirect flush,
// multi-cycle multiply freeze, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             id_is_mul_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             ex_MemToReg_i,
  input  logic             ex_RegWrite_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             stat_clr_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_write_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_bubble_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {S_RUN = 1'b0, S_MUL = 1'b1} state_t;

  // A single-cycle multiply never needs to hold EX, so the FSM is bypassed.
  localparam bit         MUL_EN    = (MUL_LAT > 1);
  localparam logic [3:0] MCNT_INIT = MUL_EN ? 4'(MUL_LAT - 2) : 4'd0;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_mcnt, w_mcnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_lu, w_redir;

  // Load in EX whose destination feeds the instruction in ID; r0 never hazards.
  assign w_lu = id_valid_i & ex_MemToReg_i & ex_RegWrite_i & (ex_rd_i != 5'd0) &
                ((ex_rd_i == id_rs_i) | (id_uses_rt_i & (ex_rd_i == id_rt_i)));
  assign w_redir = branch_taken_i | jump_i;

  // FSM state and multiply countdown registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_RUN;
      r_mcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_mcnt  <= w_mcnt_nxt;
    end
  end

  // Next-state and pipeline control; defaults are the held-in-reset values.
  always_comb begin
    w_state_nxt     = r_state;
    w_mcnt_nxt      = r_mcnt;
    pc_write_o      = 1'b0;
    if_id_write_o   = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_write_o   = 1'b1;
    id_ex_bubble_o  = 1'b1;
    ex_mem_bubble_o = 1'b0;
    busy_o          = 1'b0;
    if (rst_n_i) begin
      case (r_state)
        S_MUL: begin
          // Freeze the front end; EX keeps the multiply, MEM gets bubbles.
          id_ex_write_o   = 1'b0;
          id_ex_bubble_o  = 1'b0;
          ex_mem_bubble_o = 1'b1;
          busy_o          = 1'b1;
          if (r_mcnt == 4'd0) w_state_nxt = S_RUN;
          else                w_mcnt_nxt  = r_mcnt - 4'd1;
        end
        default: begin
          if (w_lu) begin
            // Load-use wins over redirect: branch operands are stale this cycle.
            id_ex_bubble_o = 1'b1;
          end else begin
            pc_write_o     = 1'b1;
            if_id_write_o  = 1'b1;
            id_ex_bubble_o = 1'b0;
            if_id_flush_o  = w_redir;
            if (MUL_EN && id_valid_i && id_is_mul_i) begin
              w_state_nxt = S_MUL;
              w_mcnt_nxt  = MCNT_INIT;
            end
          end
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC held; clear takes priority.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                             r_stall_cnt <= '0;
    else if (stat_clr_i)                      r_stall_cnt <= '0;
    else if (!pc_write_o && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: three configurations share stimulus; a behavioural model
// pushes expected outputs each cycle, which are popped and compared mid-cycle.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, id_valid, uses_rt, is_mul, br, jmp, mtr, rw, clr;
  logic [4:0] rs, rt, rd;

  logic        pcw[3], ifw[3], fl[3], idw[3], bub[3], exb[3], busy[3];
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(16)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_rs_i(rs), .id_rt_i(rt),
    .id_uses_rt_i(uses_rt), .id_is_mul_i(is_mul), .branch_taken_i(br), .jump_i(jmp),
    .ex_MemToReg_i(mtr), .ex_RegWrite_i(rw), .ex_rd_i(rd), .stat_clr_i(clr),
    .pc_write_o(pcw[0]), .if_id_write_o(ifw[0]), .if_id_flush_o(fl[0]),
    .id_ex_write_o(idw[0]), .id_ex_bubble_o(bub[0]), .ex_mem_bubble_o(exb[0]),
    .busy_o(busy[0]), .stall_cnt_o(cnt0));

  pipe_hazard_ctrl #(.MUL_LAT(1), .CNT_W(16)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_rs_i(rs), .id_rt_i(rt),
    .id_uses_rt_i(uses_rt), .id_is_mul_i(is_mul), .branch_taken_i(br), .jump_i(jmp),
    .ex_MemToReg_i(mtr), .ex_RegWrite_i(rw), .ex_rd_i(rd), .stat_clr_i(clr),
    .pc_write_o(pcw[1]), .if_id_write_o(ifw[1]), .if_id_flush_o(fl[1]),
    .id_ex_write_o(idw[1]), .id_ex_bubble_o(bub[1]), .ex_mem_bubble_o(exb[1]),
    .busy_o(busy[1]), .stall_cnt_o(cnt1));

  pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) u2 (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_rs_i(rs), .id_rt_i(rt),
    .id_uses_rt_i(uses_rt), .id_is_mul_i(is_mul), .branch_taken_i(br), .jump_i(jmp),
    .ex_MemToReg_i(mtr), .ex_RegWrite_i(rw), .ex_rd_i(rd), .stat_clr_i(clr),
    .pc_write_o(pcw[2]), .if_id_write_o(ifw[2]), .if_id_flush_o(fl[2]),
    .id_ex_write_o(idw[2]), .id_ex_bubble_o(bub[2]), .ex_mem_bubble_o(exb[2]),
    .busy_o(busy[2]), .stall_cnt_o(cnt2));

  typedef struct {int pcw; int ifw; int fl; int idw; int bub; int exb; int busy; int cnt;} obs_t;

  obs_t sbq[$];
  int   n_cmp = 0, n_bad = 0, u1_busy_seen = 0;
  int   LAT[3]  = '{4, 1, 4};
  int   CMAX[3] = '{65535, 65535, 15};
  int   m_mul[3], m_mcnt[3], m_cnt[3];

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic obs_t model_out(input int k, input bit lu, input bit redir);
    obs_t e;
    e = '{0, 0, 0, 1, 1, 0, 0, m_cnt[k]};
    if (!rst_n) e.cnt = 0;
    else if (m_mul[k] != 0) e = '{0, 0, 0, 0, 0, 1, 1, m_cnt[k]};
    else if (lu)            e = '{0, 0, 0, 1, 1, 0, 0, m_cnt[k]};
    else                    e = '{1, 1, int'(redir), 1, 0, 0, 0, m_cnt[k]};
    return e;
  endfunction

  function automatic obs_t dut_out(input int k);
    obs_t a;
    a.pcw = int'(pcw[k]); a.ifw = int'(ifw[k]); a.fl = int'(fl[k]); a.idw = int'(idw[k]);
    a.bub = int'(bub[k]); a.exb = int'(exb[k]); a.busy = int'(busy[k]);
    a.cnt = (k == 0) ? int'(cnt0) : (k == 1) ? int'(cnt1) : int'(cnt2);
    return a;
  endfunction

  // One clock cycle: inputs already driven at posedge+1.
  task automatic step();
    bit lu, redir;
    obs_t e, a;
    lu = id_valid && mtr && rw && (rd != 0) && ((rd == rs) || (uses_rt && rd == rt));
    redir = br || jmp;
    if (!rst_n) for (int k = 0; k < 3; k++) begin m_mul[k] = 0; m_mcnt[k] = 0; m_cnt[k] = 0; end
    for (int k = 0; k < 3; k++) sbq.push_back(model_out(k, lu, redir));
    #3;
    for (int k = 0; k < 3; k++) begin
      e = sbq.pop_front();
      a = dut_out(k);
      chk($sformatf("u%0d.pc_write", k),  a.pcw,  e.pcw);
      chk($sformatf("u%0d.if_id_write", k), a.ifw, e.ifw);
      chk($sformatf("u%0d.flush", k),     a.fl,   e.fl);
      chk($sformatf("u%0d.id_ex_write", k), a.idw, e.idw);
      chk($sformatf("u%0d.id_ex_bubble", k), a.bub, e.bub);
      chk($sformatf("u%0d.ex_mem_bubble", k), a.exb, e.exb);
      chk($sformatf("u%0d.busy", k),      a.busy, e.busy);
      chk($sformatf("u%0d.stall_cnt", k), a.cnt,  e.cnt);
    end
    if (busy[1]) u1_busy_seen++;
    @(posedge clk);
    if (rst_n) for (int k = 0; k < 3; k++) begin
      e = model_out(k, lu, redir);
      if (clr) m_cnt[k] = 0;
      else if (e.pcw == 0 && m_cnt[k] < CMAX[k]) m_cnt[k]++;
      if (m_mul[k] != 0) begin
        if (m_mcnt[k] == 0) m_mul[k] = 0; else m_mcnt[k]--;
      end else if (!lu && id_valid && is_mul && LAT[k] > 1) begin
        m_mul[k] = 1; m_mcnt[k] = LAT[k] - 2;
      end
    end
    #1;
  endtask

  task automatic idle();
    id_valid = 0; uses_rt = 0; is_mul = 0; br = 0; jmp = 0;
    mtr = 0; rw = 0; clr = 0; rs = 0; rt = 0; rd = 0;
  endtask

  task automatic set_load(input logic [4:0] d);
    mtr = 1; rw = 1; rd = d;
  endtask

  initial begin
    idle();
    rst_n = 0;
    for (int k = 0; k < 3; k++) begin m_mul[k] = 0; m_mcnt[k] = 0; m_cnt[k] = 0; end
    @(posedge clk); #1;
    step(); step();
    rst_n = 1;
    step();
    chk("cnt_after_reset", int'(cnt0), 0);

    // Load-use on rs: one stall cycle, then normal issue.
    id_valid = 1; rs = 8; set_load(8);
    step();
    chk("lu_pc_held_cnt", int'(cnt0), 1);
    mtr = 0;
    step();
    chk("lu_single_stall", int'(cnt0), 1);

    // No false hazards: r0 destination, rt match without rt use; then real rt use.
    rs = 0; set_load(0);            step();
    rs = 3; rt = 9; set_load(9);    step();
    uses_rt = 1;                    step();
    uses_rt = 0; rw = 0;            step();

    // Branch concurrent with load-use: stall wins, flush on the following cycle.
    rs = 5; set_load(5); br = 1;    step();
    mtr = 0;                        step();
    br = 0; jmp = 1;                step();
    idle();                         step();

    // Multiply: clear counter, issue, let it drain.
    clr = 1;                        step();
    clr = 0; id_valid = 1; is_mul = 1; step();
    is_mul = 0;
    for (int i = 0; i < 4; i++) step();
    chk("mul_stall_cnt", int'(cnt0), 3);
    chk("mul1_cnt", int'(cnt1), 0);

    // Reset in the middle of a multiply.
    is_mul = 1; step();
    is_mul = 0; step();
    rst_n = 0;  step();
    chk("rst_mid_busy", int'(busy[0]), 0);
    rst_n = 1;  step(); step();

    // Saturation on the 4-bit counter, then clear while still stalled.
    id_valid = 1; rs = 7; set_load(7);
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", int'(cnt2), 15);
    clr = 1; step();
    chk("clr_under_stall", int'(cnt2), 0);
    clr = 0; step();
    idle(); step();

    // Random traffic over a small register space to provoke overlaps.
    for (int i = 0; i < 300; i++) begin
      id_valid = 1'($urandom % 2); uses_rt = 1'($urandom % 2);
      is_mul = ($urandom % 8) == 0; br = ($urandom % 6) == 0; jmp = ($urandom % 10) == 0;
      mtr = 1'($urandom % 2); rw = ($urandom % 4) != 0; clr = ($urandom % 40) == 0;
      rs = 5'($urandom % 4); rt = 5'($urandom % 4); rd = 5'($urandom % 4);
      rst_n = ($urandom % 100) != 0;
      step();
    end
    rst_n = 1; idle(); step();

    chk("mul1_never_busy", u1_busy_seen, 0);
    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
